// File: rtl/led_pattern_pkg.sv
// Shared types and field widths for the LED pattern transmitter.
package led_pattern_pkg;

   localparam int unsigned CNT_W = 4;
   localparam int unsigned PER_W = 8;

   typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BLINK, MODE_RSVD} mode_e;
   typedef enum logic [1:0] {IDLE, HOLD, ON_PH, OFF_PH} state_e;

endpackage

// File: rtl/tick_gen.sv
// Tick prescaler: one-cycle tick every CLK_HZ/TICK_HZ clocks, restartable via clr_i.
module tick_gen #(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned TICK_HZ = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   assign tick_o = (r_cnt == TC);

   always_ff @(posedge clk) begin
      if (rst || clr_i || tick_o) r_cnt <= '0;
      else                        r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/led_pattern_tx.sv
// Drives one LED as off, steady on, or N blinks at a PWM brightness from a
// valid/ready command; reports busy and a one-cycle done pulse.
module led_pattern_tx
   import led_pattern_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned TICK_HZ = 1000,
   parameter int unsigned PWM_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [1:0]       cmd_mode_i,
   input  logic [CNT_W-1:0] cmd_count_i,
   input  logic [PER_W-1:0] cmd_period_i,
   input  logic [PWM_W-1:0] cmd_duty_i,
   output logic             led_o,
   output logic             busy_o,
   output logic             done_o
);

   state_e           r_state;
   state_e           w_state_nx;
   logic [PER_W-1:0] r_timer;
   logic [PER_W-1:0] r_period;
   logic [CNT_W-1:0] r_remain;
   logic [PWM_W-1:0] r_duty;
   logic [PWM_W-1:0] r_pwm_cnt;
   logic             w_accept;
   logic             w_tick;
   logic             w_done_nx;
   logic [PWM_W-1:0] w_duty_nx;
   logic             w_pwm_on;
   logic             w_led_nx;
   logic [PER_W-1:0] w_period_eff;
   logic             w_expire;

   assign cmd_ready_o  = (r_state == IDLE) || (r_state == HOLD);
   assign w_accept     = cmd_valid_i && cmd_ready_o;
   assign w_period_eff = (cmd_period_i == '0) ? PER_W'(1) : cmd_period_i;
   assign w_expire     = w_tick && (r_timer == PER_W'(1));

   tick_gen #(
      .CLK_HZ (CLK_HZ),
      .TICK_HZ(TICK_HZ)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clr_i (w_accept),
      .tick_o(w_tick)
   );

   always_comb begin
      w_state_nx = r_state;
      w_done_nx  = 1'b0;
      case (r_state)
         IDLE, HOLD: begin
            if (w_accept) begin
               case (mode_e'(cmd_mode_i))
                  MODE_ON: w_state_nx = HOLD;
                  MODE_BLINK: begin
                     if (cmd_count_i != '0) begin
                        w_state_nx = ON_PH;
                     end else begin
                        w_state_nx = IDLE;
                        w_done_nx  = 1'b1;
                     end
                  end
                  default: begin
                     w_state_nx = IDLE;
                     w_done_nx  = 1'b1;
                  end
               endcase
            end
         end
         ON_PH: if (w_expire) w_state_nx = OFF_PH;
         OFF_PH: begin
            if (w_expire) begin
               if (r_remain == CNT_W'(1)) begin
                  w_state_nx = IDLE;
                  w_done_nx  = 1'b1;
               end else begin
                  w_state_nx = ON_PH;
               end
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // LED register is fed from the next state and next duty so it changes
   // on the cycle right after an accept or an expiring tick.
   assign w_duty_nx = w_accept ? cmd_duty_i : r_duty;
   assign w_pwm_on  = (w_duty_nx == '1) || (r_pwm_cnt < w_duty_nx);
   assign w_led_nx  = ((w_state_nx == HOLD) || (w_state_nx == ON_PH)) && w_pwm_on;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_timer   <= '0;
         r_period  <= '0;
         r_remain  <= '0;
         r_duty    <= '0;
         r_pwm_cnt <= '0;
         led_o     <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
         led_o     <= w_led_nx;
         busy_o    <= (w_state_nx == ON_PH) || (w_state_nx == OFF_PH);
         done_o    <= w_done_nx;
         if (w_accept) begin
            r_duty   <= cmd_duty_i;
            r_period <= w_period_eff;
            r_timer  <= w_period_eff;
            r_remain <= cmd_count_i;
         end else if (w_tick && ((r_state == ON_PH) || (r_state == OFF_PH))) begin
            if (r_timer == PER_W'(1)) begin
               r_timer <= r_period;
               if (r_state == OFF_PH) r_remain <= r_remain - 1'b1;
            end else begin
               r_timer <= r_timer - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_led_pattern_tx.sv
// Scoreboard bench for led_pattern_tx: expected LED/busy waveform from a
// per-command timing model, expected done cycles queued at accept time.
module tb_led_pattern_tx;

   localparam int unsigned DIV = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid_i = 1'b0;
   logic       cmd_ready_o;
   logic [1:0] cmd_mode_i = '0;
   logic [3:0] cmd_count_i = '0;
   logic [7:0] cmd_period_i = '0;
   logic [7:0] cmd_duty_i = '0;
   logic       led_o, busy_o, done_o;

   led_pattern_tx #(
      .CLK_HZ (100),
      .TICK_HZ(10),
      .PWM_W  (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_mode_i  (cmd_mode_i),
      .cmd_count_i (cmd_count_i),
      .cmd_period_i(cmd_period_i),
      .cmd_duty_i  (cmd_duty_i),
      .led_o       (led_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Model of the active command: 0 idle, 1 steady on, 2 blink train.
   int          m_kind = 0;
   int          m_T = 0;
   int          m_H = 0;
   int          m_cnt = 0;
   logic [7:0]  m_duty = '0;
   int unsigned sb[$];
   bit          mon_en = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_accept(input logic [1:0] mode, input logic [3:0] cnt,
                               input logic [7:0] per, input logic [7:0] duty,
                               input int unsigned t);
      int h;
      h = DIV * ((per == 0) ? 1 : int'(per));
      m_T = int'(t);
      m_duty = duty;
      if (mode == 2'd1) begin
         m_kind = 1;
      end else if (mode == 2'd2 && cnt != 0) begin
         m_kind = 2;
         m_H = h;
         m_cnt = int'(cnt);
         sb.push_back(t + 2 * h * cnt);
      end else begin
         m_kind = 0;
         sb.push_back(t);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accept edge.
   task automatic issue(input logic [1:0] mode, input logic [3:0] cnt,
                        input logic [7:0] per, input logic [7:0] duty,
                        output int unsigned t_acc);
      bit ok = 0;
      int unsigned waited = 0;
      t_acc = 0;
      cmd_mode_i = mode; cmd_count_i = cnt; cmd_period_i = per; cmd_duty_i = duty;
      cmd_valid_i = 1'b1;
      while (!ok && waited < 8000) begin
         if (cmd_ready_o) begin
            t_acc = cyc + 1;
            ok = 1;
            @(posedge clk);
         end else begin
            @(negedge clk);
            waited++;
         end
      end
      if (!ok) check("accept_timeout", 0, 1);
      else     model_accept(mode, cnt, per, duty, t_acc);
      @(negedge clk);
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_drain();
      int unsigned n = 0;
      while (sb.size() != 0 && n < 8000) begin
         @(negedge clk);
         n++;
      end
      check("done_drain", sb.size(), 0);
   endtask

   // Monitor: compares LED/busy/ready against the model each cycle and pops
   // the done scoreboard whenever the DUT pulses done.
   always @(negedge clk) begin
      int   k;
      bit   exp_busy;
      bit   chk_led;
      bit   exp_led;
      if (mon_en && !rst) begin
         exp_busy = 0;
         chk_led  = 1;
         exp_led  = 0;
         k = int'(cyc) - m_T + 1;
         if (m_kind == 1 || (m_kind == 2 && k >= 1 && k <= 2 * m_H * m_cnt)) begin
            if (m_kind == 2) exp_busy = 1;
            if (m_kind == 1 || ((k - 1) / m_H) % 2 == 0) begin
               if (m_duty == 8'hFF)      exp_led = 1;
               else if (m_duty == 8'h00) exp_led = 0;
               else                      chk_led = 0;
            end
         end
         if (chk_led) check("led", led_o, exp_led);
         check("busy", busy_o, exp_busy);
         check("ready", cmd_ready_o, !exp_busy);
         if (done_o) begin
            if (sb.size() == 0) check("done_unexpected", 1, 0);
            else                check("done_cycle", int'(cyc), int'(sb.pop_front()));
         end else if (sb.size() != 0 && sb[0] < cyc) begin
            check("done_missing", int'(cyc), int'(sb.pop_front()));
         end
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t, t2;
      int          hi;
      logic [1:0]  md;
      logic [7:0]  du;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_led", led_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_ready", cmd_ready_o, 1);
      mon_en = 1;
      repeat (3) @(negedge clk);

      // Blink x2, half-period 3 ticks, then an ON held while busy.
      issue(2'd2, 4'd2, 8'd3, 8'hFF, t);
      issue(2'd1, 4'd0, 8'd0, 8'hFF, t2);
      check("held_accept_cycle", int'(t2), int'(t + 121));
      repeat (20) @(negedge clk);

      // ON at quarter brightness, then OFF.
      issue(2'd1, 4'd0, 8'd0, 8'd64, t);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         hi += int'(led_o);
         @(negedge clk);
      end
      check("pwm_high_count", hi, 64);
      issue(2'd0, 4'd0, 8'd0, 8'd0, t);
      check("off_led_next", led_o, 0);
      wait_drain();

      // Boundaries: count 0, period 0, duty 0, reserved mode, maxima.
      issue(2'd2, 4'd0, 8'd5, 8'hFF, t);
      wait_drain();
      issue(2'd2, 4'd1, 8'd0, 8'hFF, t);
      wait_drain();
      issue(2'd1, 4'd0, 8'd0, 8'd0, t);
      repeat (15) @(negedge clk);
      check("duty0_hold_ready", cmd_ready_o, 1);
      issue(2'd3, 4'd7, 8'd2, 8'hFF, t);
      wait_drain();
      issue(2'd2, 4'd15, 8'd1, 8'hFF, t);
      wait_drain();
      issue(2'd2, 4'd1, 8'd255, 8'hFF, t);
      wait_drain();

      // Randomized commands.
      for (int i = 0; i < 24; i++) begin
         md = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 2))
            0:       du = 8'h00;
            1:       du = 8'hFF;
            default: du = 8'($urandom_range(1, 254));
         endcase
         issue(md, 4'($urandom_range(0, 4)), 8'($urandom_range(0, 4)), du, t);
         if (md == 2'd1) repeat ($urandom_range(3, 40)) @(negedge clk);
         else            wait_drain();
      end

      // Reset in the middle of a 3-blink train.
      issue(2'd2, 4'd3, 8'd3, 8'hFF, t);
      while (cyc < t + 44) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      m_kind = 0;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      check("midrst_led", led_o, 0);
      check("midrst_busy", busy_o, 0);
      check("midrst_done", done_o, 0);
      check("midrst_ready", cmd_ready_o, 1);
      repeat (30) @(negedge clk);
      issue(2'd2, 4'd1, 8'd1, 8'hFF, t);
      wait_drain();

      repeat (10) @(negedge clk);
      check("final_sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
